// File: rtl/cnu_minsum_ctrl_pkg.sv
// Shared LDPC decoder definitions: check-node controller states and default sizing.
package cnu_minsum_ctrl_pkg;

  localparam int DEF_WIDTH = 7;
  localparam int DEF_DEG   = 24;
  localparam int DEF_IDXW  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } cnu_state_e;

endpackage

// File: rtl/cnu_minsum_ctrl_comp3in2out.sv
// Three-input comparator returning the smallest and second-smallest magnitude.
module comp3in2out #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2
);

  logic c12, c13, c23;

  assign c12 = (in_1 <= in_2);
  assign c13 = (in_1 <= in_3);
  assign c23 = (in_2 <= in_3);

  // Non-strict compares make every tie resolve to a real input, never the default.
  always_comb begin
    out_1 = '1;
    out_2 = '1;
    if (c12 && c13) begin
      out_1 = in_1;
      out_2 = c23 ? in_2 : in_3;
    end else if (!c12 && c23) begin
      out_1 = in_2;
      out_2 = c13 ? in_1 : in_3;
    end else begin
      out_1 = in_3;
      out_2 = c12 ? in_1 : in_2;
    end
  end

endmodule

// File: rtl/cnu_minsum_ctrl.sv
// Min-sum check-node controller: accumulates one row of DEG magnitudes/signs into min, second min, argmin and sign product.
module cnu_minsum_ctrl
  import cnu_minsum_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEG   = DEF_DEG,
  parameter int IDXW  = DEF_IDXW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mag,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] min_v,
  output logic [WIDTH-1:0] submin_v,
  output logic [IDXW-1:0]  min_idx,
  output logic             sign_prod,
  output logic             busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEG - 1);

  cnu_state_e       state_q, state_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] submin_q, submin_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             sign_q, sign_d;

  logic [WIDTH-1:0] cmp_min, cmp_sub;
  logic             accept;

  comp3in2out #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .in_1  (min_q),
    .in_2  (submin_q),
    .in_3  (in_mag),
    .out_1 (cmp_min),
    .out_2 (cmp_sub)
  );

  assign accept = in_valid && (state_q == ST_ACCUM);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    min_d    = min_q;
    submin_d = submin_q;
    idx_d    = idx_q;
    sign_d   = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ACCUM;
          cnt_d    = '0;
          min_d    = '1;
          submin_d = '1;
          idx_d    = '0;
          sign_d   = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          min_d    = cmp_min;
          submin_d = cmp_sub;
          // Strict compare: on ties the earliest position keeps the index.
          if (in_mag < min_q) idx_d = cnt_q;
          sign_d = sign_q ^ in_sign;
          cnt_d  = cnt_q + IDXW'(1);
          if (cnt_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      min_q    <= '1;
      submin_q <= '1;
      idx_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      min_q    <= min_d;
      submin_q <= submin_d;
      idx_q    <= idx_d;
      sign_q   <= sign_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign min_v     = min_q;
  assign submin_v  = submin_q;
  assign min_idx   = idx_q;
  assign sign_prod = sign_q;

endmodule

// File: tb/tb_cnu_minsum_ctrl.sv
// Directed and reference-model bench for cnu_minsum_ctrl at DEG=4 and DEG=24.
module tb_cnu_minsum_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_start, a_in_valid, a_in_ready, a_in_sign;
  logic       a_out_valid, a_out_ready, a_sign_prod, a_busy;
  logic [6:0] a_in_mag, a_min_v, a_submin_v;
  logic [1:0] a_min_idx;

  logic       b_start, b_in_valid, b_in_ready, b_in_sign;
  logic       b_out_valid, b_out_ready, b_sign_prod, b_busy;
  logic [6:0] b_in_mag, b_min_v, b_submin_v;
  logic [4:0] b_min_idx;

  int checks = 0;
  int errors = 0;

  logic [6:0] r_min, r_sub;
  logic [1:0] r_idx;
  logic       r_sgn;

  cnu_minsum_ctrl #(.WIDTH(7), .DEG(4), .IDXW(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mag(a_in_mag), .in_sign(a_in_sign), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .min_v(a_min_v), .submin_v(a_submin_v), .min_idx(a_min_idx), .sign_prod(a_sign_prod),
    .busy(a_busy)
  );

  cnu_minsum_ctrl #(.WIDTH(7), .DEG(24), .IDXW(5)) u_dut24 (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mag(b_in_mag), .in_sign(b_in_sign), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .min_v(b_min_v), .submin_v(b_submin_v), .min_idx(b_min_idx), .sign_prod(b_sign_prod),
    .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One DEG=4 row; called and left at a falling edge. Captures results into r_*.
  task automatic row4(input int m0, input int m1, input int m2, input int m3,
                      input bit s0, input bit s1, input bit s2, input bit s3,
                      input int gap, input int hold, input bit poke);
    int m[4];
    bit s[4];
    m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    a_start = 1'b1;
    @(negedge clk);
    a_start = poke;
    chk("busy_accum", a_busy, 1);
    chk("ready_accum", a_in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          a_in_valid = 1'b0;
          @(negedge clk);
          chk("gap_no_ov", a_out_valid, 0);
          chk("gap_busy", a_busy, 1);
        end
      end
      a_in_valid = 1'b1;
      a_in_mag   = 7'(m[i]);
      a_in_sign  = s[i];
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_in_mag   = '0;
    a_in_sign  = 1'b0;
    chk("ov_after_last", a_out_valid, 1);
    chk("ready_done", a_in_ready, 0);
    r_min = a_min_v;
    r_sub = a_submin_v;
    r_idx = a_min_idx;
    r_sgn = a_sign_prod;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_ov", a_out_valid, 1);
      chk("hold_busy", a_busy, 1);
      chk("hold_stable", {a_min_v, a_submin_v, a_min_idx, a_sign_prod},
          {r_min, r_sub, r_idx, r_sgn});
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    a_start     = 1'b0;
    chk("ov_cleared", a_out_valid, 0);
    chk("idle_busy", a_busy, 0);
    @(negedge clk);
    chk("no_restart", a_busy, 0);
  endtask

  initial begin
    int mn, sb, ix, sg, mg, sv, wmax;

    rst = 1'b1;
    a_start = 0; a_in_valid = 0; a_in_mag = 0; a_in_sign = 0; a_out_ready = 0;
    b_start = 0; b_in_valid = 0; b_in_mag = 0; b_in_sign = 0; b_out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_sign", a_sign_prod, 0);
    chk("rst_idx", a_min_idx, 0);
    chk("rst_min", a_min_v, 127);
    chk("rst_submin", a_submin_v, 127);
    chk("rst_busy24", b_busy, 0);
    chk("rst_min24", b_min_v, 127);

    // Basic gap-free row.
    row4(9, 3, 5, 7, 1, 0, 1, 1, 0, 0, 0);
    chk("basic_min", r_min, 3);
    chk("basic_sub", r_sub, 5);
    chk("basic_idx", r_idx, 1);
    chk("basic_sign", r_sgn, 1);

    // All magnitudes equal.
    row4(4, 4, 4, 4, 0, 1, 0, 0, 0, 0, 0);
    chk("tie_min", r_min, 4);
    chk("tie_sub", r_sub, 4);
    chk("tie_idx", r_idx, 0);
    chk("tie_sign", r_sgn, 1);

    // Backpressure: two-cycle input gaps, consumer stalls 5 cycles.
    row4(9, 3, 5, 7, 1, 0, 1, 1, 2, 5, 0);
    chk("bp_min", r_min, 3);
    chk("bp_sub", r_sub, 5);
    chk("bp_idx", r_idx, 1);
    chk("bp_sign", r_sgn, 1);

    // Start held high through ACCUM and DONE must not retrigger.
    row4(10, 20, 5, 5, 0, 0, 0, 0, 1, 2, 1);
    chk("poke_min", r_min, 5);
    chk("poke_sub", r_sub, 5);
    chk("poke_idx", r_idx, 2);
    chk("poke_sign", r_sgn, 0);

    // Reset after two accepts, with competing start/in_valid/out_ready.
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1; a_in_mag = 7'd0; a_in_sign = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1; a_start = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_start = 1'b0; a_out_ready = 1'b0; a_in_valid = 1'b0;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_ready", a_in_ready, 0);
    chk("mid_rst_ov", a_out_valid, 0);
    chk("mid_rst_min", a_min_v, 127);
    chk("mid_rst_sub", a_submin_v, 127);
    chk("mid_rst_idx", a_min_idx, 0);
    chk("mid_rst_sign", a_sign_prod, 0);
    row4(2, 8, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    chk("fresh_min", r_min, 1);
    chk("fresh_sub", r_sub, 2);
    chk("fresh_idx", r_idx, 2);
    chk("fresh_sign", r_sgn, 0);

    // DEG=24 rows against a reference model; odd rows use a narrow range to force ties.
    for (int row = 0; row < 1000; row++) begin
      wmax = (row % 2 == 1) ? 15 : 127;
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      mn = 127; sb = 127; ix = 0; sg = 0;
      for (int i = 0; i < 24; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          b_in_valid = 1'b0;
          @(negedge clk);
        end
        mg = int'($urandom_range(0, wmax));
        sv = int'($urandom_range(0, 1));
        if (mg < mn) begin
          sb = mn; mn = mg; ix = i;
        end else if (mg < sb) begin
          sb = mg;
        end
        sg = sg ^ sv;
        b_in_valid = 1'b1;
        b_in_mag   = 7'(mg);
        b_in_sign  = sv[0];
        @(negedge clk);
      end
      b_in_valid = 1'b0;
      chk("r24_ov", b_out_valid, 1);
      chk("r24_min", b_min_v, mn);
      chk("r24_sub", b_submin_v, sb);
      chk("r24_idx", b_min_idx, ix);
      chk("r24_sign", b_sign_prod, sg);
      b_out_ready = 1'b1;
      @(negedge clk);
      b_out_ready = 1'b0;
      chk("r24_idle", b_busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
